riscv_str_alu: RTL and testbench
================================

RISCV_STR_ALU -- requirements
Module: riscv_str_alu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand/result width; legal values 32 and 64; NBYTES = DATA_WIDTH/8.
REQ-002 Parameter LEET_RULES_PER_CYCLE, default 1, SHALL set the leet rules applied per step; legal values 1, 2, 4; NSTEPS = 4/LEET_RULES_PER_CYCLE.
REQ-003 Port clk, input, 1 bit: the block's single clock.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port enable_i, input, 1 bit: a string op is presented in the EX stage this cycle.
REQ-006 Port operator_i, input, STR_OP_WIDTH bits: operation select.
REQ-007 Port flush_i, input, 1 bit: synchronous abort of any multi-cycle op.
REQ-008 Port ex_ready_i, input, 1 bit: EX stage can accept a result this cycle.
REQ-009 Port operand_i, input, DATA_WIDTH bits: NBYTES characters; byte 0 is [7:0].
REQ-010 Port result_o, output, DATA_WIDTH bits: operation result.
REQ-011 Port ready_o, output, 1 bit: result_o is valid, or the block is idle.

Function
REQ-012 The block SHALL process bytes independently; every byte not matched by an op's rule SHALL pass through unchanged.
REQ-013 STR_OP_UPPER SHALL map 0x61..0x7A to byte-0x20; single-cycle.
REQ-014 STR_OP_LOWER SHALL map 0x41..0x5A (inclusive; not 0x5B..0x5C) to byte+0x20; single-cycle.
REQ-015 STR_OP_ROT13 SHALL rotate 0x41..0x5A and 0x61..0x7A by 13 within their case range; single-cycle.
REQ-016 STR_OP_STRLEN SHALL return the zero-extended index of the lowest 0x00 byte, or NBYTES if none; single-cycle.
REQ-017 For single-cycle ops, result_o SHALL be valid combinationally in the cycle enable_i is high, and ready_o SHALL be 1.
REQ-018 STR_OP_LEET SHALL apply the 4-entry rule table in package order: e/E->'3', s/S->'5', l/L->'1', o/O->'0'.
REQ-019 The LEET FSM SHALL have states IDLE, STEP, DONE, with a step counter of width clog2(NSTEPS)+1.
REQ-020 IDLE: when enable_i=1 and operator_i=LEET, the FSM SHALL capture operand_i into the work register, drive ready_o=0 in the same cycle, and go to STEP with counter=0.
REQ-021 STEP: each cycle SHALL apply the next LEET_RULES_PER_CYCLE rules to the work register and hold ready_o=0; after NSTEPS cycles the FSM SHALL go to DONE.
REQ-022 Latency: if LEET is accepted in cycle T, DONE SHALL be reached in cycle T+NSTEPS+1, with ready_o=1 and result_o equal to the work register.
REQ-023 DONE: the FSM SHALL go to IDLE when ex_ready_i=1; otherwise it SHALL stay in DONE with result_o held stable.
REQ-024 A LEET presented in the cycle after DONE->IDLE SHALL start a new operation.
REQ-025 flush_i=1 SHALL force the next state to IDLE from any state, overriding ex_ready_i and any new LEET start; the work register is don't-care afterwards.
REQ-026 result_o SHALL be 0 when enable_i=0, for an undefined operator, and during IDLE/STEP of a LEET op.
REQ-027 Outside LEET STEP, ready_o SHALL be 1 whenever the FSM is IDLE with no LEET start, or in DONE.

Reset
REQ-028 rst_n=0 SHALL asynchronously force the FSM to IDLE, the counter to 0 and the work register to 0; ready_o SHALL then read 1 and result_o 0 (enable_i=0).
REQ-029 Reset asserted mid-STEP or in DONE SHALL abandon the op; after release the block SHALL be IDLE.

Structure
REQ-030 STR_OP_WIDTH, the operator codes (UPPER, LOWER, ROT13, LEET, STRLEN) and the leet rule table (match-upper, match-lower, replacement) SHALL live in riscv_defines.
REQ-031 The per-byte combinational transform SHALL be a sub-module riscv_str_byte_op, instantiated NBYTES times for UPPER/LOWER/ROT13.
REQ-032 The LEET FSM state type SHALL be local to riscv_str_alu.

Verification
REQ-033 UPPER, operand 0x617A6241 -> result 0x415A4241, ready_o=1 in the same cycle.
REQ-034 LOWER 0x5B5A4140 -> 0x5B7A6140; ROT13 0x6E6D4E4D -> 0x617A415A.
REQ-035 STRLEN 0x41004242 -> 2; 0x41414141 -> 4 (DATA_WIDTH=32); 0x...00 in byte 0 -> 0.
REQ-036 LEET 0x6F6C7365, R=1 -> ready_o=0 for 5 cycles, then 0x30313533; with ex_ready_i held 0 for 3 cycles, result_o is stable and ready_o=1 throughout; with R=4 -> ready_o=0 for 2 cycles.
REQ-037 flush_i pulsed in STEP cycle 2 -> IDLE next cycle, ready_o=1, result_o=0; a LEET issued next starts cleanly.
REQ-038 rst_n dropped mid-STEP (asynchronous, between clock edges) -> immediate IDLE; DATA_WIDTH=64 regression repeats REQ-033..REQ-036 on 8-byte operands.

Source files
------------

// File: rtl/riscv_str_alu_pkg.sv
// Shared definitions for the string ALU.
//   riscv_defines      : operator width and codes, leet rule table.
//   riscv_str_alu_pkg  : character-class and per-byte leet helpers.
// No ports; imported by the interface, the sub-module and the top.
package riscv_defines;

  localparam int STR_OP_WIDTH = 3;

  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER  = 3'd0;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER  = 3'd1;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13  = 3'd2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET   = 3'd3;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_STRLEN = 3'd4;

  typedef struct packed {
    logic [7:0] match_upper;
    logic [7:0] match_lower;
    logic [7:0] repl;
  } leet_rule_t;

  localparam int LEET_NRULES = 4;

  // Applied in table order: e->3, s->5, l->1, o->0.
  localparam leet_rule_t [0:LEET_NRULES-1] LEET_RULES = '{
    '{8'h45, 8'h65, 8'h33},
    '{8'h53, 8'h73, 8'h35},
    '{8'h4C, 8'h6C, 8'h31},
    '{8'h4F, 8'h6F, 8'h30}
  };

endpackage

package riscv_str_alu_pkg;
  import riscv_defines::*;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= 8'h61) && (b <= 8'h7A);
  endfunction

  // Apply one leet rule to a single character.
  function automatic logic [7:0] leet_byte(input logic [7:0] b, input logic [1:0] idx);
    leet_rule_t r;
    r = LEET_RULES[idx];
    if ((b == r.match_upper) || (b == r.match_lower)) begin
      return r.repl;
    end
    return b;
  endfunction

endpackage

// File: rtl/riscv_str_alu_if.sv
// EX-stage request/response bundle for the string ALU.
//   master : drives enable_i, operator_i, flush_i, ex_ready_i, operand_i
//   slave  : the ALU; drives result_o, ready_o
interface riscv_str_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                                  enable_i;
  logic [riscv_defines::STR_OP_WIDTH-1:0] operator_i;
  logic                                  flush_i;
  logic                                  ex_ready_i;
  logic [DATA_WIDTH-1:0]                 operand_i;
  logic [DATA_WIDTH-1:0]                 result_o;
  logic                                  ready_o;

  modport master (
    output enable_i, operator_i, flush_i, ex_ready_i, operand_i,
    input  result_o, ready_o
  );

  modport slave (
    input  enable_i, operator_i, flush_i, ex_ready_i, operand_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/riscv_str_alu_byte_op.sv
// Single-character combinational transform for UPPER, LOWER and ROT13.
//   operator_i : operation select (other codes pass the byte through)
//   byte_i     : input character
//   byte_o     : transformed character
module riscv_str_byte_op
  import riscv_defines::*;
  import riscv_str_alu_pkg::*;
(
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [7:0]              byte_i,
  output logic [7:0]              byte_o
);

  always_comb begin
    byte_o = byte_i;
    case (operator_i)
      STR_OP_UPPER: begin
        if (is_lower(byte_i)) byte_o = byte_i - 8'h20;
      end
      STR_OP_LOWER: begin
        if (is_upper(byte_i)) byte_o = byte_i + 8'h20;
      end
      STR_OP_ROT13: begin
        // First half of each case range moves up, second half wraps down.
        if (is_upper(byte_i)) begin
          byte_o = (byte_i < 8'h4E) ? byte_i + 8'd13 : byte_i - 8'd13;
        end else if (is_lower(byte_i)) begin
          byte_o = (byte_i < 8'h6E) ? byte_i + 8'd13 : byte_i - 8'd13;
        end
      end
      default: byte_o = byte_i;
    endcase
  end

endmodule

// File: rtl/riscv_str_alu.sv
// String ALU for the EX stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : riscv_str_alu_if.slave (request in, result/ready out)
// UPPER, LOWER, ROT13 and STRLEN complete combinationally in the issue
// cycle. LEET runs a small FSM that applies LEET_RULES_PER_CYCLE rules per
// step and then holds the result until the EX stage takes it.
//
//   state | meaning
//   IDLE  | no LEET in flight; single-cycle ops served combinationally
//   STEP  | applying rules to the work register, ready_o low
//   DONE  | LEET result held on result_o until ex_ready_i
module riscv_str_alu
  import riscv_defines::*;
  import riscv_str_alu_pkg::*;
#(
  parameter int DATA_WIDTH           = 32,
  parameter int LEET_RULES_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  riscv_str_alu_if.slave  bus
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int NSTEPS = LEET_NRULES / LEET_RULES_PER_CYCLE;
  localparam int CNT_W  = $clog2(NSTEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } leet_state_e;

  leet_state_e           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] work_q;
  logic [DATA_WIDTH-1:0] work_step;
  logic [DATA_WIDTH-1:0] byte_res;
  logic [DATA_WIDTH-1:0] strlen_res;
  logic                  leet_start;

  // A flush in the issue cycle suppresses the start.
  assign leet_start = bus.enable_i && (bus.operator_i == STR_OP_LEET) && !bus.flush_i;

  for (genvar g = 0; g < NBYTES; g++) begin : g_byte
    riscv_str_byte_op u_byte_op (
      .operator_i (bus.operator_i),
      .byte_i     (bus.operand_i[8*g +: 8]),
      .byte_o     (byte_res[8*g +: 8])
    );
  end

  // Scan from the top so the lowest zero byte wins.
  always_comb begin
    strlen_res = DATA_WIDTH'(NBYTES);
    for (int b = NBYTES - 1; b >= 0; b--) begin
      if (bus.operand_i[8*b +: 8] == 8'h00) strlen_res = DATA_WIDTH'(b);
    end
  end

  // Rules for step cnt_q are cnt_q*R .. cnt_q*R+R-1 of the table.
  always_comb begin
    work_step = work_q;
    for (int r = 0; r < LEET_RULES_PER_CYCLE; r++) begin
      for (int b = 0; b < NBYTES; b++) begin
        work_step[8*b +: 8] = leet_byte(work_step[8*b +: 8],
                                        2'(int'(cnt_q) * LEET_RULES_PER_CYCLE + r));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else if (bus.flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (leet_start) begin
            work_q  <= bus.operand_i;
            cnt_q   <= '0;
            state_q <= STEP;
          end
        end
        STEP: begin
          work_q <= work_step;
          if (cnt_q == LAST_STEP) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.ex_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ready_o must drop in the LEET issue cycle itself, so the outputs are a
  // decode of the registered state plus the live request.
  always_comb begin
    bus.ready_o  = 1'b1;
    bus.result_o = '0;
    case (state_q)
      IDLE: begin
        if (leet_start) begin
          bus.ready_o = 1'b0;
        end else if (bus.enable_i) begin
          case (bus.operator_i)
            STR_OP_UPPER,
            STR_OP_LOWER,
            STR_OP_ROT13:  bus.result_o = byte_res;
            STR_OP_STRLEN: bus.result_o = strlen_res;
            default:       bus.result_o = '0;
          endcase
        end
      end
      STEP:    bus.ready_o  = 1'b0;
      DONE:    bus.result_o = work_q;
      default: bus.ready_o  = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_riscv_str_alu.sv
// Self-checking bench: three ALUs (32b R=1, 32b R=4, 64b R=2) driven in
// lockstep from a vector table plus hand-written LEET/flush/reset sequences.
module tb_riscv_str_alu;
  import riscv_defines::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  riscv_str_alu_if #(.DATA_WIDTH(32)) ifa ();
  riscv_str_alu_if #(.DATA_WIDTH(32)) ifb ();
  riscv_str_alu_if #(.DATA_WIDTH(64)) ifc ();

  riscv_str_alu #(.DATA_WIDTH(32), .LEET_RULES_PER_CYCLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  riscv_str_alu #(.DATA_WIDTH(32), .LEET_RULES_PER_CYCLE(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  riscv_str_alu #(.DATA_WIDTH(64), .LEET_RULES_PER_CYCLE(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [2:0]  op;
    logic [31:0] opd32;
    logic [31:0] exp32;
    logic [63:0] opd64;
    logic [63:0] exp64;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] op, input logic fl, input logic exr,
                       input logic [31:0] o32, input logic [63:0] o64);
    ifa.enable_i = en; ifa.operator_i = op; ifa.flush_i = fl; ifa.ex_ready_i = exr; ifa.operand_i = o32;
    ifb.enable_i = en; ifb.operator_i = op; ifb.flush_i = fl; ifb.ex_ready_i = exr; ifb.operand_i = o32;
    ifc.enable_i = en; ifc.operator_i = op; ifc.flush_i = fl; ifc.ex_ready_i = exr; ifc.operand_i = o64;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_rdy_a"}, 64'(ifa.ready_o), 64'd1);
    chk({nm, "_rdy_b"}, 64'(ifb.ready_o), 64'd1);
    chk({nm, "_rdy_c"}, 64'(ifc.ready_o), 64'd1);
    chk({nm, "_res_a"}, 64'(ifa.result_o), 64'd0);
    chk({nm, "_res_c"}, ifc.result_o, 64'd0);
  endtask

  // Issues a LEET in the current cycle, counts ready_o-low cycles per DUT
  // (issue cycle included) and checks the DONE result. Leaves all DUTs in
  // DONE with ex_ready_i low, returning just after a rising edge.
  task automatic run_leet(input logic [31:0] o32, input logic [63:0] o64,
                          input logic [31:0] e32, input logic [63:0] e64);
    int na, nb, nc, iter;
    bit da, db, dc;
    na = 0; nb = 0; nc = 0; da = 0; db = 0; dc = 0; iter = 0;
    drive(1'b1, STR_OP_LEET, 1'b0, 1'b0, o32, o64);
    forever begin
      @(negedge clk);
      if (!da) begin if (ifa.ready_o) da = 1; else na++; end
      if (!db) begin if (ifb.ready_o) db = 1; else nb++; end
      if (!dc) begin if (ifc.ready_o) dc = 1; else nc++; end
      iter++;
      if ((da && db && dc) || iter >= 12) break;
      @(posedge clk); #1;
    end
    chk("leet_busy_a_r1", 64'(na), 64'd5);
    chk("leet_busy_b_r4", 64'(nb), 64'd2);
    chk("leet_busy_c_r2", 64'(nc), 64'd3);
    chk("leet_res_a", 64'(ifa.result_o), 64'(e32));
    chk("leet_res_b", 64'(ifb.result_o), 64'(e32));
    chk("leet_res_c", ifc.result_o, e64);
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    //            en    op             opd32         exp32         opd64                  exp64
    vecs[0] = '{1'b1, STR_OP_UPPER,  32'h617A6241, 32'h415A4241, 64'h617A6241_7B604060, 64'h415A4241_7B604060};
    vecs[1] = '{1'b1, STR_OP_LOWER,  32'h5B5A4140, 32'h5B7A6140, 64'h5B5A4140_5C412020, 64'h5B7A6140_5C612020};
    vecs[2] = '{1'b1, STR_OP_ROT13,  32'h6E6D4E4D, 32'h617A415A, 64'h6E6D4E4D_3F416120, 64'h617A415A_3F4E6E20};
    vecs[3] = '{1'b1, STR_OP_STRLEN, 32'h41004242, 32'd2,        64'h41414141_41004242, 64'd2};
    vecs[4] = '{1'b1, STR_OP_STRLEN, 32'h41414141, 32'd4,        64'h41414141_41414141, 64'd8};
    vecs[5] = '{1'b1, STR_OP_STRLEN, 32'h41414100, 32'd0,        64'h00000000_41414100, 64'd0};
    vecs[6] = '{1'b1, STR_OP_STRLEN, 32'h00414141, 32'd3,        64'h00414141_41414141, 64'd7};
    vecs[7] = '{1'b1, 3'd6,          32'h61626364, 32'd0,        64'h61626364_61626364, 64'd0};
    vecs[8] = '{1'b0, STR_OP_UPPER,  32'h61626364, 32'd0,        64'h61626364_61626364, 64'd0};
    vecs[9] = '{1'b1, STR_OP_UPPER,  32'h7B607A61, 32'h7B605A41, 64'h41424344_61626364, 64'h41424344_41424344};

    rst_n = 1'b0;
    drive(1'b0, STR_OP_UPPER, 1'b0, 1'b0, 32'h0, 64'h0);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].en, vecs[i].op, 1'b0, 1'b1, vecs[i].opd32, vecs[i].opd64);
      @(negedge clk);
      chk($sformatf("vec%0d_res_a", i), 64'(ifa.result_o), 64'(vecs[i].exp32));
      chk($sformatf("vec%0d_rdy_a", i), 64'(ifa.ready_o), 64'd1);
      chk($sformatf("vec%0d_res_b", i), 64'(ifb.result_o), 64'(vecs[i].exp32));
      chk($sformatf("vec%0d_res_c", i), ifc.result_o, vecs[i].exp64);
      chk($sformatf("vec%0d_rdy_c", i), 64'(ifc.ready_o), 64'd1);
      @(posedge clk); #1;
    end

    // LEET latency, then a 3-cycle stall in DONE.
    run_leet(32'h6F6C7365, 64'h4F4C5345_6F6C7365, 32'h30313533, 64'h30313533_30313533);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_rdy_a", k), 64'(ifa.ready_o), 64'd1);
      chk($sformatf("stall%0d_res_a", k), 64'(ifa.result_o), 64'h30313533);
      chk($sformatf("stall%0d_res_c", k), ifc.result_o, 64'h30313533_30313533);
      @(posedge clk); #1;
    end

    // Release with LEET still requested: DONE this cycle, new start the next.
    drive(1'b1, STR_OP_LEET, 1'b0, 1'b1, 32'h45454545, 64'h45454545_45454545);
    @(negedge clk);
    chk("release_rdy_a", 64'(ifa.ready_o), 64'd1);
    @(posedge clk); #1;
    drive(1'b1, STR_OP_LEET, 1'b0, 1'b0, 32'h45454545, 64'h45454545_45454545);
    @(negedge clk);
    chk("restart_rdy_a", 64'(ifa.ready_o), 64'd0);
    chk("restart_res_a", 64'(ifa.result_o), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("step1_rdy_a", 64'(ifa.ready_o), 64'd0);
    chk("step1_res_a", 64'(ifa.result_o), 64'd0);
    @(posedge clk); #1;
    drive(1'b0, STR_OP_LEET, 1'b1, 1'b0, 32'h0, 64'h0);
    @(posedge clk); #1;
    drive(1'b0, STR_OP_LEET, 1'b0, 1'b0, 32'h0, 64'h0);
    @(negedge clk);
    chk_idle("flush");
    @(posedge clk); #1;
    run_leet(32'h4C4F5345, 64'h4C4F5345_656C736F, 32'h31303533, 64'h31303533_33313530);
    drive(1'b0, STR_OP_UPPER, 1'b0, 1'b1, 32'h0, 64'h0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of STEP.
    drive(1'b1, STR_OP_LEET, 1'b0, 1'b0, 32'h6F6C7365, 64'h6F6C7365_6F6C7365);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    drive(1'b0, STR_OP_UPPER, 1'b0, 1'b0, 32'h0, 64'h0);
    #1;
    chk_idle("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");
    @(posedge clk); #1;
    run_leet(32'h6F6C7365, 64'h6F6C7365_6F6C7365, 32'h30313533, 64'h30313533_30313533);
    drive(1'b0, STR_OP_UPPER, 1'b0, 1'b1, 32'h0, 64'h0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
